// File: rtl/div_seq_if.sv
// Operand/result handshake bundle for div_seq.
// Source side: in_valid/dividend/divisor out, in_ready in; result side:
// out_valid/quotient/remainder/div_zero in, out_ready out (from master view).
interface div_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   // Environment driving operands and consuming results
   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero
   );

   // The divider itself
   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero
   );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring unsigned divider: one WIDTH-bit trial subtraction per
// clock, WIDTH iterations per result; a zero divisor short-circuits to DONE.
// Ports: clk, rst (async, active-high), bus (div_seq_if.slave):
//   in_valid/in_ready/dividend/divisor  operand handshake (accept in IDLE)
//   out_valid/out_ready/quotient/remainder/div_zero  result handshake
// WIDTH must be at least 2.
module div_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   div_seq_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] d;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             div_zero_r;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [WIDTH:0]   rs;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] q_nxt;

   // One restoring step. Since r < d is kept invariant, rs < 2*d, so the top
   // bit of the (WIDTH+1)-bit difference is exactly the borrow (rs < d).
   always_comb begin
      rs     = {r, q[WIDTH-1]};
      diff   = rs - {1'b0, d};
      borrow = diff[WIDTH];
      r_nxt  = borrow ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
      q_nxt  = {q[WIDTH-2:0], ~borrow};
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         q           <= '0;
         r           <= '0;
         d           <= '0;
         cnt         <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         div_zero_r  <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  d          <= bus.divisor;
                  q          <= bus.dividend;
                  r          <= '0;
                  cnt        <= '0;
                  div_zero_r <= 1'b0;
                  in_ready_r <= 1'b0;
                  if (bus.divisor == '0) begin
                     quotient_r  <= '1;
                     remainder_r <= bus.dividend;
                     div_zero_r  <= 1'b1;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               q   <= q_nxt;
               r   <= r_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  quotient_r  <= q_nxt;
                  remainder_r <= r_nxt;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               // Results stay on quotient/remainder after the transfer
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq (WIDTH=8): stimulus pushes hand-computed
// results, a negedge monitor pops and compares on each result transfer.
module tb_div_seq;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   results_seen = 0;
   exp_t sb[$];

   div_seq_if #(.WIDTH(W)) bus ();

   div_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: a transfer happens on the posedge following a negedge where
   // out_valid && out_ready
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         results_seen++;
         check("no_ready_valid_overlap", 32'(bus.in_ready), 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0d/%0d required=none", bus.quotient, bus.remainder);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient",  32'(bus.quotient),  32'(e.q));
            check("remainder", 32'(bus.remainder), 32'(e.r));
            check("div_zero",  32'(bus.div_zero),  32'(e.dz));
         end
      end
   end

   // Issue one division and measure accept-to-out_valid latency in edges
   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic edz, input int exp_lat, input logic scramble);
      int n;
      int lat;
      exp_t e;
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      e.q = eq;
      e.r = er;
      e.dz = edz;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (scramble) begin
         bus.dividend = 8'hAA;
         bus.divisor  = 8'h55;
      end
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
         check("in_ready_after_transfer", 32'(bus.in_ready), 32'd1);
         check("out_valid_after_transfer", 32'(bus.out_valid), 32'd0);
         check("quotient_held", 32'(bus.quotient), 32'(eq));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_quotient",  32'(bus.quotient),  32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_div_zero",  32'(bus.div_zero),  32'd0);
      rst = 1'b0;

      // Nominal vectors
      run(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 9, 1'b0);
      run(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9, 1'b0);
      run(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 9, 1'b0);
      run(8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 9, 1'b0);
      run(8'd200, 8'd200, 8'd1,   8'd0, 1'b0, 9, 1'b0);

      // Zero divisor then recovery
      run(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1, 1'b0);
      run(8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 9, 1'b0);

      // Operands changed during CALC are ignored
      run(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 9, 1'b1);

      // Backpressure: hold result for 20 cycles with a stray in_valid pulse
      bus.out_ready = 1'b0;
      run(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 9, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_quotient",  32'(bus.quotient),  32'd14);
         check("bp_remainder", 32'(bus.remainder), 32'd2);
         check("bp_in_ready",  32'(bus.in_ready),  32'd0);
         bus.in_valid = (i == 5);
         bus.dividend = 8'h11;
         bus.divisor  = 8'h02;
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_transfer_one_cycle", 32'(bus.out_valid), 32'd0);
      check("bp_in_ready_back",      32'(bus.in_ready),  32'd1);

      // Async reset on the 4th CALC cycle of 200/13
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd13;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_quotient",  32'(bus.quotient),  32'd0);
      check("arst_remainder", 32'(bus.remainder), 32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_in_ready",  32'(bus.in_ready),  32'd1);
      check("arst_div_zero",  32'(bus.div_zero),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      run(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 9, 1'b0);

      repeat (3) @(negedge clk);
      check("sb_drained",   32'(sb.size()),     32'd0);
      check("results_seen", 32'(results_seen),  32'd10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
